// File: rtl/calc_display_pkg.sv
// Shared types and constants for the calculator result display: FSM states,
// display geometry and active-low seven-segment glyphs {g,f,e,d,c,b,a}.
package calc_display_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} dispState_e;

  localparam int unsigned NUM_BCD_DIGITS = 10;
  localparam int unsigned NUM_POS        = 8;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;

  function automatic logic [6:0] digitGlyph(input logic [3:0] digit);
    logic [6:0] glyph;
    case (digit)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    return glyph;
  endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Sequential double-dabble converter: captures a two's-complement word on start,
// takes its magnitude, then performs 32 add-3/shift steps into a 10-digit BCD scratch.
module bin2bcd_dd
  import calc_display_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [31:0]                 value,
  output logic                        busy,
  output logic                        done,
  output logic                        negative,
  output logic [4*NUM_BCD_DIGITS-1:0] result
);

  logic [31:0]                 valueQ;
  logic [31:0]                 magQ;
  logic [4*NUM_BCD_DIGITS-1:0] scratchQ;
  logic [4*NUM_BCD_DIGITS-1:0] adjusted;
  logic [4:0]                  cntQ;
  logic                        loadQ;
  logic                        shiftQ;
  logic                        doneQ;

  always_comb begin
    adjusted = scratchQ;
    for (int i = 0; i < NUM_BCD_DIGITS; i++) begin
      if (scratchQ[4*i +: 4] >= 4'd5) begin
        adjusted[4*i +: 4] = scratchQ[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valueQ   <= '0;
      magQ     <= '0;
      scratchQ <= '0;
      cntQ     <= '0;
      loadQ    <= 1'b0;
      shiftQ   <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      doneQ <= 1'b0;
      if (start && !busy) begin
        valueQ <= value;
        loadQ  <= 1'b1;
      end
      if (loadQ) begin
        // Unsigned negate, so 0x80000000 yields 2147483648.
        magQ     <= valueQ[31] ? (~valueQ + 32'd1) : valueQ;
        scratchQ <= '0;
        cntQ     <= '0;
        loadQ    <= 1'b0;
        shiftQ   <= 1'b1;
      end
      if (shiftQ) begin
        scratchQ <= {adjusted[4*NUM_BCD_DIGITS-2:0], magQ[31]};
        magQ     <= {magQ[30:0], 1'b0};
        cntQ     <= cntQ + 5'd1;
        if (cntQ == 5'd31) begin
          shiftQ <= 1'b0;
          doneQ  <= 1'b1;
        end
      end
    end
  end

  assign busy     = loadQ | shiftQ;
  assign done     = doneQ;
  assign negative = valueQ[31];
  assign result   = scratchQ;

endmodule

// File: rtl/result_display.sv
// Captures a 32-bit result, converts it to sign + BCD and scans it onto an
// 8-position active-low seven-segment display. RESULT_DISPLAY_BLANK_EN enables leading-zero blanking.
module result_display
  import calc_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 value,
  input  logic                        value_valid,
  output logic                        busy,
  output logic                        done,
  output logic [4*NUM_BCD_DIGITS-1:0] bcd,
  output logic                        negative,
  output logic                        overflow,
  output logic [6:0]                  seg,
  output logic [NUM_POS-1:0]          an
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);

  dispState_e stateQ, stateD;

  logic                        engStart;
  logic                        engBusy;
  logic                        engDone;
  logic                        engNeg;
  logic [4*NUM_BCD_DIGITS-1:0] engResult;
  logic                        engOvf;
  logic                        loadOut;

  logic [4*NUM_BCD_DIGITS-1:0] bcdQ;
  logic                        negQ;
  logic                        ovfQ;

  logic [CntW-1:0]             refreshCntQ;
  logic [2:0]                  posQ;
  logic [6:0]                  segQ;
  logic [NUM_POS-1:0]          anQ;
  logic [6:0]                  glyph;

  assign engStart = (stateQ == StIdle) && value_valid;

  bin2bcd_dd u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (engStart),
    .value    (value),
    .busy     (engBusy),
    .done     (engDone),
    .negative (engNeg),
    .result   (engResult)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      StIdle:  if (value_valid) stateD = StLoad;
      StLoad:  if (engBusy) stateD = StShift;
      StShift: if (engDone) stateD = StDone;
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_comb begin
    busy    = (stateQ != StIdle);
    done    = (stateQ == StDone);
    // Results are latched as the engine finishes so they are visible in the done cycle.
    loadOut = (stateQ == StShift) && engDone;
  end

  assign engOvf = (|engResult[39:32]) | (engNeg & (|engResult[39:28]));

  always_ff @(posedge clk) begin
    if (rst) begin
      bcdQ <= '0;
      negQ <= 1'b0;
      ovfQ <= 1'b0;
    end else if (loadOut) begin
      bcdQ <= engResult;
      negQ <= engNeg;
      ovfQ <= engOvf;
    end
  end

  assign bcd      = bcdQ;
  assign negative = negQ;
  assign overflow = ovfQ;

`ifdef RESULT_DISPLAY_BLANK_EN
  logic [2:0] msd;
`endif

  always_comb begin
    glyph = digitGlyph(bcdQ[{posQ, 2'b00} +: 4]);
`ifdef RESULT_DISPLAY_BLANK_EN
    msd = 3'd0;
    for (int k = 1; k < NUM_POS; k++) begin
      if (bcdQ[4*k +: 4] != 4'd0) msd = 3'(k);
    end
`endif
    if (ovfQ) begin
      glyph = (posQ == 3'd0) ? SEG_E : SEG_BLANK;
    end else begin
`ifdef RESULT_DISPLAY_BLANK_EN
      if (posQ > msd) begin
        glyph = (negQ && (posQ == msd + 3'd1)) ? SEG_MINUS : SEG_BLANK;
      end
`else
      if (negQ && (posQ == 3'(NUM_POS - 1))) glyph = SEG_MINUS;
`endif
    end
  end

  // seg and an are registered together so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      refreshCntQ <= '0;
      posQ        <= 3'd0;
      segQ        <= SEG_0;
      anQ         <= ~NUM_POS'(1);
    end else begin
      if (refreshCntQ == CntLast) begin
        refreshCntQ <= '0;
        posQ        <= posQ + 3'd1;
      end else begin
        refreshCntQ <= refreshCntQ + CntW'(1);
      end
      segQ <= glyph;
      anQ  <= ~(NUM_POS'(1) << posQ);
    end
  end

  assign seg = segQ;
  assign an  = anQ;

endmodule

// File: tb/tb_result_display.sv
// Directed bench for result_display with a one-cycle refresh slot; expected
// values are hand-derived BCD words and glyph codes.
module tb_result_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        value_valid;
  logic        busy;
  logic        done;
  logic [39:0] bcd;
  logic        negative;
  logic        overflow;
  logic [6:0]  seg;
  logic [7:0]  an;

  int checks = 0;
  int errors = 0;

`ifdef RESULT_DISPLAY_BLANK_EN
  localparam logic [6:0] LZ     = 7'h7F;
  localparam logic [6:0] NEG_P1 = 7'h3F;
  localparam logic [6:0] NEG_P7 = 7'h7F;
`else
  localparam logic [6:0] LZ     = 7'h40;
  localparam logic [6:0] NEG_P1 = 7'h40;
  localparam logic [6:0] NEG_P7 = 7'h3F;
`endif

  always #5 clk = ~clk;

  result_display #(.REFRESH_DIV(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .value_valid (value_valid),
    .busy        (busy),
    .done        (done),
    .bcd         (bcd),
    .negative    (negative),
    .overflow    (overflow),
    .seg         (seg),
    .an          (an)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request and track busy/done over 40 cycles; optionally pulse
  // value_valid again while busy, which must be ignored.
  task automatic convert(input logic [31:0] v, input logic pulseMid,
                         input logic [39:0] prevBcd);
    int nDone  = 0;
    int doneAt = 0;
    @(negedge clk);
    value       = v;
    value_valid = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        nDone++;
        doneAt = i;
      end
      if (i == 1)  chk("busy_n1", busy, 1'b1);
      if (i == 34) chk("bcd_hold_n34", bcd, prevBcd);
      if (i == 35) chk("busy_n35", busy, 1'b1);
      if (i == 36) chk("busy_n36", busy, 1'b0);
      value_valid = pulseMid && (i == 5);
    end
    chk("done_count", nDone, 1);
    chk("done_cycle", doneAt, 35);
  endtask

  task automatic checkPos(input int k, input logic [6:0] exp);
    logic [7:0] want;
    logic       found = 1'b0;
    want = ~(8'd1 << k);
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an === want) found = 1'b1;
    end
    chk("scan_found", found, 1'b1);
    chk($sformatf("seg_pos%0d", k), seg, exp);
  endtask

  initial begin
    rst         = 1'b1;
    value       = 32'd777;
    value_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_an", an, 8'hFE);
    chk("rst_seg", seg, 7'h40);
    chk("rst_bcd", bcd, 40'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_neg", negative, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    rst         = 1'b0;
    value_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wins_busy", busy, 1'b0);
    chk("rst_wins_done", done, 1'b0);

    convert(32'd12345, 1'b0, 40'h0);
    chk("b12345_bcd", bcd, 40'h0000012345);
    chk("b12345_neg", negative, 1'b0);
    chk("b12345_ovf", overflow, 1'b0);
    checkPos(0, 7'h12);
    checkPos(4, 7'h79);
    checkPos(5, LZ);
    checkPos(6, LZ);
    checkPos(7, LZ);

    convert(32'hFFFF_FFFF, 1'b1, 40'h0000012345);
    chk("m1_bcd", bcd, 40'h1);
    chk("m1_neg", negative, 1'b1);
    chk("m1_ovf", overflow, 1'b0);
    checkPos(0, 7'h79);
    checkPos(1, NEG_P1);
    checkPos(7, NEG_P7);

    convert(32'h8000_0000, 1'b0, 40'h1);
    chk("min_bcd", bcd, 40'h2147483648);
    chk("min_neg", negative, 1'b1);
    chk("min_ovf", overflow, 1'b1);
    checkPos(0, 7'h06);
    checkPos(3, 7'h7F);
    checkPos(7, 7'h7F);

    convert(32'd99999999, 1'b0, 40'h2147483648);
    chk("n9s_bcd", bcd, 40'h0099999999);
    chk("n9s_ovf", overflow, 1'b0);
    for (int k = 0; k < 8; k++) checkPos(k, 7'h10);

    convert(32'd100000000, 1'b0, 40'h0099999999);
    chk("e8_bcd", bcd, 40'h0100000000);
    chk("e8_ovf", overflow, 1'b1);
    checkPos(0, 7'h06);
    checkPos(1, 7'h7F);

    // -9999999 fits with its sign; -10000000 does not.
    convert(32'hFF67_6981, 1'b0, 40'h0100000000);
    chk("m7_bcd", bcd, 40'h0009999999);
    chk("m7_ovf", overflow, 1'b0);
    checkPos(0, 7'h10);
    checkPos(6, 7'h10);
    checkPos(7, 7'h3F);

    convert(32'hFF67_6980, 1'b0, 40'h0009999999);
    chk("m8_bcd", bcd, 40'h0010000000);
    chk("m8_neg", negative, 1'b1);
    chk("m8_ovf", overflow, 1'b1);
    checkPos(0, 7'h06);

    // Reset on the 10th SHIFT cycle (cycle N+11).
    @(negedge clk);
    value       = 32'd4660;
    value_valid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      @(posedge clk);
      @(negedge clk);
      value_valid = 1'b0;
      chk("midrst_nodone", done, 1'b0);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_bcd", bcd, 40'h0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_an", an, 8'hFE);
    chk("midrst_seg", seg, 7'h40);
    rst = 1'b0;
    begin
      int lateDone = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done) lateDone++;
      end
      chk("midrst_no_late_done", lateDone, 0);
    end
    checkPos(0, 7'h40);
    checkPos(1, LZ);

    convert(32'd4660, 1'b0, 40'h0);
    chk("after_rst_bcd", bcd, 40'h0000004660);
    chk("after_rst_neg", negative, 1'b0);
    checkPos(0, 7'h40);
    checkPos(1, 7'h02);
    checkPos(3, 7'h19);
    checkPos(4, LZ);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
